// File: rtl/mp3_sample_streamer.sv
// mp3_sample_streamer
// Reads a run of 1024-bit words from an on-chip memory and streams each
// word out as 64 consecutive 16-bit PCM samples over a valid/ready interface.
// Sample 0 of a word is bits [15:0], sample 63 is bits [1023:1008].
//
// Ports
//   clk            : sole clock, all state on rising edge
//   reset_n        : asynchronous active-low reset
//   start          : single-cycle request to begin a pass (honoured in IDLE only)
//   abort          : synchronous stop request, returns to IDLE without done
//   busy           : high in any state other than IDLE
//   done           : one-cycle pulse when a non-looping pass completes
//   mem_address    : word address to the memory slave
//   mem_chipselect : memory select (read only), high only during FETCH
//   mem_clken      : memory clock enable, high only during FETCH
//   mem_readdata   : memory read word, valid one cycle after the address
//   sample_data    : current PCM sample
//   sample_valid   : sample_data valid
//   sample_ready   : downstream accepts the sample
//   sample_last    : final sample of a non-looping pass
module mp3_sample_streamer #(
    parameter int START_ADDR = 0,
    parameter int NUM_WORDS  = 500,
    parameter int LOOP       = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [8:0]    mem_address,
    output logic          mem_chipselect,
    output logic          mem_clken,
    input  logic [1023:0] mem_readdata,
    output logic [15:0]   sample_data,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          sample_last
);

    localparam logic [8:0] START_PTR = 9'(START_ADDR);
    localparam logic [8:0] LAST_PTR  = 9'(START_ADDR + NUM_WORDS - 1);
    localparam bit         NO_LOOP   = (LOOP == 0);

    // The word range must fit inside the 9-bit address space.
    if (NUM_WORDS < 1 || NUM_WORDS > 512 || START_ADDR < 0 ||
        START_ADDR + NUM_WORDS - 1 > 511) begin : g_paramCheck
        $error("mp3_sample_streamer: START_ADDR/NUM_WORDS exceed the 512-word memory");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [8:0]      r_wordPtr;
    logic [5:0]      r_idx;
    logic [1023:0]   r_buffer;

    logic            w_lastWord;
    logic [5:0]      w_nextIdx;

    assign w_lastWord = (r_wordPtr == LAST_PTR);
    assign w_nextIdx  = r_idx + 6'd1;

    // All outputs are registered and updated together with the state, so
    // each branch below sets the values the outputs must show in the next
    // state. In STREAM sample_valid is always high, so sample_ready alone
    // marks a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_wordPtr      <= '0;
            r_idx          <= '0;
            r_buffer       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            sample_last    <= 1'b0;
        end else if (r_state != S_IDLE && abort) begin
            // Abort wins over any transfer in the same cycle.
            r_state        <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            sample_valid   <= 1'b0;
            sample_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_wordPtr      <= START_PTR;
                        mem_address    <= START_PTR;
                        mem_chipselect <= 1'b1;
                        mem_clken      <= 1'b1;
                        busy           <= 1'b1;
                        r_state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_chipselect <= 1'b0;
                    mem_clken      <= 1'b0;
                    r_state        <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_buffer     <= mem_readdata;
                    r_idx        <= '0;
                    sample_data  <= mem_readdata[15:0];
                    sample_valid <= 1'b1;
                    sample_last  <= 1'b0;
                    r_state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (sample_ready) begin
                        if (r_idx != 6'd63) begin
                            r_idx       <= w_nextIdx;
                            sample_data <= r_buffer[{w_nextIdx, 4'b0000} +: 16];
                            sample_last <= (w_nextIdx == 6'd63) && w_lastWord && NO_LOOP;
                        end else begin
                            sample_valid <= 1'b0;
                            sample_last  <= 1'b0;
                            if (!w_lastWord) begin
                                r_wordPtr      <= r_wordPtr + 9'd1;
                                mem_address    <= r_wordPtr + 9'd1;
                                mem_chipselect <= 1'b1;
                                mem_clken      <= 1'b1;
                                r_state        <= S_FETCH;
                            end else if (!NO_LOOP) begin
                                r_wordPtr      <= START_PTR;
                                mem_address    <= START_PTR;
                                mem_chipselect <= 1'b1;
                                mem_clken      <= 1'b1;
                                r_state        <= S_FETCH;
                            end else begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_sample_streamer.sv
// tb_mp3_sample_streamer
// Self-checking bench for mp3_sample_streamer. Instance A runs a two-word
// non-looping pass starting at word 5; instance B runs a one-word looping
// pass at word 0. Expected samples and fetch addresses are queued when a
// pass is started and compared as the DUT presents them.
module tb_mp3_sample_streamer;

    logic          clk = 1'b0;
    logic          reset_n;

    logic          startA, abortA, readyA;
    logic          busyA, doneA, csA, clkenA, validA, lastA;
    logic [8:0]    addrA;
    logic [15:0]   dataA;
    logic [1023:0] rdA = '0;

    logic          startB, abortB, readyB;
    logic          busyB, doneB, csB, clkenB, validB, lastB;
    logic [8:0]    addrB;
    logic [15:0]   dataB;
    logic [1023:0] rdB = '0;

    int checkCount = 0;
    int passCount  = 0;

    logic [16:0] sampQA[$];
    logic [8:0]  addrQA[$];
    logic [16:0] sampQB[$];
    logic [8:0]  addrQB[$];

    int xferCountA  = 0;
    int doneCountA  = 0;
    int gapA        = 0;
    bit expectDoneA = 1'b0;
    int fetchCountB = 0;
    int doneCountB  = 0;

    always #5 clk = ~clk;

    mp3_sample_streamer #(.START_ADDR(5), .NUM_WORDS(2), .LOOP(0)) u_dutA (
        .clk(clk), .reset_n(reset_n), .start(startA), .abort(abortA),
        .busy(busyA), .done(doneA), .mem_address(addrA),
        .mem_chipselect(csA), .mem_clken(clkenA), .mem_readdata(rdA),
        .sample_data(dataA), .sample_valid(validA), .sample_ready(readyA),
        .sample_last(lastA)
    );

    mp3_sample_streamer #(.START_ADDR(0), .NUM_WORDS(1), .LOOP(1)) u_dutB (
        .clk(clk), .reset_n(reset_n), .start(startB), .abort(abortB),
        .busy(busyB), .done(doneB), .mem_address(addrB),
        .mem_chipselect(csB), .mem_clken(clkenB), .mem_readdata(rdB),
        .sample_data(dataB), .sample_valid(validB), .sample_ready(readyB),
        .sample_last(lastB)
    );

    // Memory for A: word w sample k holds {w-5, k}; word 5 -> 0x00kk, word 6 -> 0x01kk.
    function automatic logic [1023:0] wordA(input logic [8:0] a);
        logic [1023:0] w;
        logic [7:0]    hi;
        hi = 8'(a) - 8'd5;
        for (int k = 0; k < 64; k++) w[16*k +: 16] = {hi, 8'(k)};
        return w;
    endfunction

    // Memory for B: every sample k holds 0xA000 + k.
    function automatic logic [1023:0] wordB();
        logic [1023:0] w;
        for (int k = 0; k < 64; k++) w[16*k +: 16] = 16'hA000 + 16'(k);
        return w;
    endfunction

    always @(posedge clk) begin
        if (csA && clkenA) rdA <= wordA(addrA);
        if (csB && clkenB) rdB <= wordB();
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Monitor for A: fetch addresses, sample data/last against the queue front
    // (also on stall cycles), done one cycle after the last transfer, and the
    // two-cycle bubble before each word's samples.
    always @(negedge clk) begin
        if (reset_n) begin
            if (expectDoneA) begin
                checkOutput("A_done_pulse", doneA, 1);
                expectDoneA = 1'b0;
            end
            if (doneA) doneCountA++;
            if (csA) begin
                checkOutput("A_clken", clkenA, 1);
                checkOutput("A_addrQ_nonempty", addrQA.size() > 0, 1);
                if (addrQA.size() > 0) checkOutput("A_mem_address", addrA, addrQA.pop_front());
            end
            if (validA) begin
                checkOutput("A_sampQ_nonempty", sampQA.size() > 0, 1);
                if (sampQA.size() > 0) begin
                    checkOutput("A_sample", {lastA, dataA}, sampQA[0]);
                    if (readyA) begin
                        if (sampQA[0][16]) expectDoneA = 1'b1;
                        void'(sampQA.pop_front());
                        xferCountA++;
                    end
                end
            end
            if (!busyA) gapA = 0;
            else if (!validA) gapA++;
            else begin
                if (gapA > 0) checkOutput("A_bubble", gapA, 2);
                gapA = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (doneB) doneCountB++;
            if (csB) begin
                fetchCountB++;
                checkOutput("B_addrQ_nonempty", addrQB.size() > 0, 1);
                if (addrQB.size() > 0) checkOutput("B_mem_address", addrB, addrQB.pop_front());
            end
            if (validB) begin
                checkOutput("B_sampQ_nonempty", sampQB.size() > 0, 1);
                if (sampQB.size() > 0) begin
                    checkOutput("B_sample", {lastB, dataB}, sampQB[0]);
                    if (readyB) void'(sampQB.pop_front());
                end
            end
        end
    end

    task automatic pushPassA();
        xferCountA = 0;
        addrQA.push_back(9'd5);
        addrQA.push_back(9'd6);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 64; k++)
                sampQA.push_back({(w == 1 && k == 63), 16'(w * 256 + k)});
    endtask

    task automatic applyStimulus();
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
    endtask

    task automatic runPassA(input int limit, input bit randomReady, input int startRepulseAt);
        int startDone;
        int cyc;
        startDone = doneCountA;
        cyc = 0;
        while (doneCountA == startDone && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            readyA = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            startA = (cyc == startRepulseAt);
        end
        startA = 1'b0;
        readyA = 1'b1;
        checkOutput("A_pass_completed", cyc < limit, 1);
        @(posedge clk); #1;
        checkOutput("A_idle_after_pass", busyA, 0);
        checkOutput("A_sampQ_drained", sampQA.size(), 0);
        checkOutput("A_addrQ_drained", addrQA.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        startA = 1'b0; abortA = 1'b0; readyA = 1'b1;
        startB = 1'b0; abortB = 1'b0; readyB = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_valid", validA, 0);
        checkOutput("rst_data", dataA, 0);
        checkOutput("rst_addr", addrA, 0);
        checkOutput("rst_cs", csA, 0);
        checkOutput("rst_B_busy", busyB, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] two-word pass, ready held high");
        pushPassA(); applyStimulus(); runPassA(600, 1'b0, 0);
        checkOutput("A1_done_count", doneCountA, 1);

        $display("[TB] two-word pass, random ready");
        pushPassA(); applyStimulus(); runPassA(3000, 1'b1, 0);
        checkOutput("A2_done_count", doneCountA, 2);

        $display("[TB] start re-pulsed mid-stream");
        pushPassA(); applyStimulus(); runPassA(600, 1'b0, 30);
        checkOutput("A3_done_count", doneCountA, 3);

        $display("[TB] start and abort together in IDLE");
        startA = 1'b1; abortA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0; abortA = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A_startabort_busy", busyA, 0);
        checkOutput("A_startabort_addr", addrA, 6);

        $display("[TB] reset during stream at sample 20");
        pushPassA(); applyStimulus();
        cyc = 0;
        while (xferCountA < 20 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("A_reached_idx20", xferCountA, 20);
        reset_n = 1'b0;
        #1;
        checkOutput("A_arst_busy", busyA, 0);
        checkOutput("A_arst_done", doneA, 0);
        checkOutput("A_arst_valid", validA, 0);
        checkOutput("A_arst_last", lastA, 0);
        checkOutput("A_arst_data", dataA, 0);
        checkOutput("A_arst_cs", csA, 0);
        checkOutput("A_arst_clken", clkenA, 0);
        checkOutput("A_arst_addr", addrA, 0);
        sampQA.delete(); addrQA.delete(); expectDoneA = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A_wait_for_start", busyA, 0);
        pushPassA(); applyStimulus(); runPassA(600, 1'b0, 0);
        checkOutput("A4_done_count", doneCountA, 4);

        $display("[TB] looping one-word pass, then abort");
        addrQB.push_back(9'd0);
        addrQB.push_back(9'd0);
        for (int k = 0; k < 64; k++) sampQB.push_back({1'b0, 16'hA000 + 16'(k)});
        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        cyc = 0;
        while (fetchCountB < 2 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("B_refetch_seen", fetchCountB, 2);
        abortB = 1'b1;
        @(posedge clk); #1;
        abortB = 1'b0;
        checkOutput("B_abort_busy", busyB, 0);
        checkOutput("B_abort_done", doneB, 0);
        checkOutput("B_abort_valid", validB, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("B_done_count", doneCountB, 0);
        checkOutput("B_sampQ_drained", sampQB.size(), 0);
        checkOutput("B_addrQ_drained", addrQB.size(), 0);
        checkOutput("B_still_idle", busyB, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
